btn_debounce_array: RTL and testbench
=====================================

BTN_DEBOUNCE_ARRAY -- requirements
Module: btn_debounce_array

Interface
REQ-001 Parameter NUM_BTN, default 4: number of independent button channels, 1..32.
REQ-002 Parameter COUNT_NUM, default 5000: stable-sample count required to accept a press or release, minimum 2.
REQ-003 Parameter ACTIVE_LOW, default 1: 1 means a raw input of 0 is "pressed"; 0 means a raw input of 1 is "pressed".
REQ-004 Parameter HOLD_NUM, default 25000000: cycles in HELD before the first auto-repeat pulse.
REQ-005 Parameter REPEAT_NUM, default 5000000: cycles between subsequent auto-repeat pulses.
REQ-006 Parameter CNT_W, default 26: counter width; must hold max(COUNT_NUM, HOLD_NUM, REPEAT_NUM).
REQ-007 iClk  in  1  single clock; all state updates on the rising edge.
REQ-008 iRst_n  in  1  asynchronous, active-low reset.
REQ-009 iBtn  in  NUM_BTN  raw, asynchronous, bouncing button inputs.
REQ-010 oPress  out  NUM_BTN  one-cycle pulse per accepted press.
REQ-011 oRelease  out  NUM_BTN  one-cycle pulse per accepted release.
REQ-012 oLevel  out  NUM_BTN  debounced pressed level: 1 in HELD and RELEASE.
REQ-013 oRepeat  out  NUM_BTN  one-cycle auto-repeat pulse.
REQ-014 oState  out  2*NUM_BTN  per-channel state code for debug; channel i occupies bits [2i+1:2i].

Function
REQ-015 Each iBtn bit shall pass through a 2-flop synchroniser; polarity shall then be normalised so that 1 means pressed.
REQ-016 Channels shall be fully independent; simultaneous events on different channels shall not interact.
REQ-017 Per-channel FSM states shall be IDLE=0, PRESS=1, HELD=2 and RELEASE=3.
REQ-018 IDLE: if the synchronised input is pressed, go to PRESS with count=0; otherwise stay in IDLE.
REQ-019 PRESS: a released sample shall return the FSM to IDLE with no pulse; a pressed sample with count==COUNT_NUM-1 shall go to HELD; otherwise count shall increment.
REQ-020 oPress shall be registered and high for exactly the first cycle in HELD.
REQ-021 Press latency: oPress shall be high in the cycle after rising edge COUNT_NUM+3, counting from the first edge at which iBtn is stably pressed.
REQ-022 HELD: a released sample shall go to RELEASE with count=0; otherwise the FSM shall stay in HELD.
REQ-023 RELEASE: a pressed sample shall return the FSM to HELD with the count cleared and no oPress or oRelease pulse.
REQ-024 RELEASE: a released sample with count==COUNT_NUM-1 shall go to IDLE, with oRelease high for exactly the first IDLE cycle; otherwise count shall increment.
REQ-025 Counters shall never wrap; the saturating compare at COUNT_NUM-1 shall be exact.
REQ-026 oPress, oRelease and oRepeat for one channel shall be mutually exclusive within any cycle.

Reset
REQ-027 Asserting iRst_n low shall, at any time including mid-PRESS or mid-RELEASE, force all channels to IDLE.
REQ-028 Reset shall clear all counters and synchroniser flops to the not-pressed value.
REQ-029 During reset, oPress, oRelease, oRepeat and oLevel shall be 0 and oState shall be all zeros.
REQ-030 The first cycle after reset release shall generate no pulse on any output, even if a button is already held.

Configuration
REQ-031 With macro BTN_AUTOREPEAT_EN defined, each channel shall run a hold counter while in HELD.
REQ-032 With BTN_AUTOREPEAT_EN, oRepeat shall pulse HOLD_NUM cycles after HELD entry, then every REPEAT_NUM cycles while the channel remains in HELD or RELEASE.
REQ-033 With BTN_AUTOREPEAT_EN, the hold counter shall reset on HELD entry from PRESS only, not on a RELEASE->HELD bounce.
REQ-034 Without BTN_AUTOREPEAT_EN, oRepeat shall be constant 0 and no hold-counter logic shall be synthesised.

Structure
REQ-035 A shared package btn_pkg shall hold the state typedef and encodings (IDLE, PRESS, HELD, RELEASE) and the default-parameter constants.
REQ-036 A sub-module btn_debounce_chan shall implement one channel (synchroniser, FSM, counters).
REQ-037 btn_debounce_array shall instantiate btn_debounce_chan NUM_BTN times via a generate loop.

Verification (COUNT_NUM=4, HOLD_NUM=10, REPEAT_NUM=5, ACTIVE_LOW=1)
REQ-038 Clean press: iBtn[0] 1->0 and held -> one oPress[0] pulse 7 edges later; oLevel[0]=1; oState[1:0]=2.
REQ-039 Bounce rejection: iBtn[1] low for 3 cycles, then high, repeated 5 times -> oPress[1] stays 0 throughout.
REQ-040 Release bounce: while HELD, iBtn[0] high for 2 cycles then low -> no oRelease[0]; FSM returns to HELD; a later 6-cycle high -> exactly one oRelease[0].
REQ-041 Simultaneous channels: iBtn=4'b0000 from 4'b1111 in the same cycle -> oPress=4'b1111 in the same cycle.
REQ-042 Reset mid-PRESS: iRst_n low for 1 cycle at PRESS count 2 -> oState=0; press then requires a full 7-edge latency.
REQ-043 Auto-repeat (macro defined): hold iBtn[2] low for 40 cycles -> oRepeat[2] pulses 10 cycles after oPress[2], then every 5 cycles; macro undefined -> oRepeat=0.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared types and default parameter values for the button debounce array.
package btn_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRESS   = 2'd1,
      HELD    = 2'd2,
      RELEASE = 2'd3
   } btnState_t;

   localparam int DEF_NUM_BTN    = 4;
   localparam int DEF_COUNT_NUM  = 5000;
   localparam int DEF_ACTIVE_LOW = 1;
   localparam int DEF_HOLD_NUM   = 25000000;
   localparam int DEF_REPEAT_NUM = 5000000;
   localparam int DEF_CNT_W      = 26;

endpackage

// File: rtl/btn_debounce_chan.sv
// One debounce channel: 2-flop synchroniser, press/release FSM and, with
// BTN_AUTOREPEAT_EN defined, a hold counter driving the auto-repeat pulse.
module btn_debounce_chan
   import btn_pkg::*;
#(
   parameter int COUNT_NUM  = DEF_COUNT_NUM,
   parameter int ACTIVE_LOW = DEF_ACTIVE_LOW,
   parameter int HOLD_NUM   = DEF_HOLD_NUM,
   parameter int REPEAT_NUM = DEF_REPEAT_NUM,
   parameter int CNT_W      = DEF_CNT_W
) (
   input  logic       iClk,
   input  logic       iRst_n,
   input  logic       iBtn,
   output logic       oPress,
   output logic       oRelease,
   output logic       oRepeat,
   output logic       oLevel,
   output logic [1:0] oState
);

   if (COUNT_NUM < 2 || HOLD_NUM < 1 || REPEAT_NUM < 1 ||
       $clog2(COUNT_NUM + 1) > CNT_W || $clog2(HOLD_NUM + 1) > CNT_W ||
       $clog2(REPEAT_NUM + 1) > CNT_W) begin : gBadParam
      $error("btn_debounce_chan: counter parameters out of range for CNT_W");
   end

   localparam logic       IDLE_RAW   = (ACTIVE_LOW != 0);
   localparam logic [CNT_W-1:0] COUNT_LAST = CNT_W'(COUNT_NUM - 1);

   logic [1:0]       syncFf;
   logic             pressed;
   btnState_t        state;
   logic [CNT_W-1:0] count;

   // NOTE: synchroniser resets to the idle raw level so no false press follows reset.
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         syncFf <= {2{IDLE_RAW}};
      end else begin
         syncFf <= {syncFf[0], iBtn};
      end
   end

   assign pressed = syncFf[1] ^ IDLE_RAW;

   // NOTE: non-blocking everywhere in sequential logic so every flop sees pre-edge values.
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         state    <= IDLE;
         count    <= '0;
         oPress   <= 1'b0;
         oRelease <= 1'b0;
      end else begin
         oPress   <= 1'b0;
         oRelease <= 1'b0;
         case (state)
            IDLE: begin
               if (pressed) begin
                  state <= PRESS;
                  count <= '0;
               end
            end
            PRESS: begin
               if (!pressed) begin
                  state <= IDLE;
               end else if (count == COUNT_LAST) begin
                  state  <= HELD;
                  oPress <= 1'b1;
               end else begin
                  count <= count + 1'b1;
               end
            end
            HELD: begin
               if (!pressed) begin
                  state <= RELEASE;
                  count <= '0;
               end
            end
            RELEASE: begin
               if (pressed) begin
                  state <= HELD;
                  count <= '0;
               end else if (count == COUNT_LAST) begin
                  state    <= IDLE;
                  oRelease <= 1'b1;
               end else begin
                  count <= count + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign oLevel = (state == HELD) || (state == RELEASE);
   assign oState = state;

`ifdef BTN_AUTOREPEAT_EN
   localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_NUM - 1);
   localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_NUM - 1);

   logic [CNT_W-1:0] holdCnt;
   logic             repeating;
   logic             enterHeld;
   logic             leaveRelease;

   assign enterHeld    = (state == PRESS) && pressed && (count == COUNT_LAST);
   assign leaveRelease = (state == RELEASE) && !pressed && (count == COUNT_LAST);

   // A RELEASE->HELD bounce keeps counting; only a fresh press restarts the hold delay.
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         holdCnt   <= '0;
         repeating <= 1'b0;
         oRepeat   <= 1'b0;
      end else begin
         oRepeat <= 1'b0;
         if (enterHeld) begin
            holdCnt   <= '0;
            repeating <= 1'b0;
         end else if (oLevel && !leaveRelease) begin
            if (holdCnt == (repeating ? REPEAT_LAST : HOLD_LAST)) begin
               holdCnt   <= '0;
               repeating <= 1'b1;
               oRepeat   <= 1'b1;
            end else begin
               holdCnt <= holdCnt + 1'b1;
            end
         end
      end
   end
`else
   assign oRepeat = 1'b0;
`endif

endmodule

// File: rtl/btn_debounce_array.sv
// NUM_BTN independent debounce channels. Define BTN_AUTOREPEAT_EN to enable
// the per-channel hold/auto-repeat logic; otherwise oRepeat is tied low.
module btn_debounce_array
   import btn_pkg::*;
#(
   parameter int NUM_BTN    = DEF_NUM_BTN,
   parameter int COUNT_NUM  = DEF_COUNT_NUM,
   parameter int ACTIVE_LOW = DEF_ACTIVE_LOW,
   parameter int HOLD_NUM   = DEF_HOLD_NUM,
   parameter int REPEAT_NUM = DEF_REPEAT_NUM,
   parameter int CNT_W      = DEF_CNT_W
) (
   input  logic                 iClk,
   input  logic                 iRst_n,
   input  logic [NUM_BTN-1:0]   iBtn,
   output logic [NUM_BTN-1:0]   oPress,
   output logic [NUM_BTN-1:0]   oRelease,
   output logic [NUM_BTN-1:0]   oLevel,
   output logic [NUM_BTN-1:0]   oRepeat,
   output logic [2*NUM_BTN-1:0] oState
);

   if (NUM_BTN < 1 || NUM_BTN > 32) begin : gBadNumBtn
      $error("btn_debounce_array: NUM_BTN must be 1..32");
   end

   for (genvar i = 0; i < NUM_BTN; i++) begin : gChan
      btn_debounce_chan #(
         .COUNT_NUM  (COUNT_NUM),
         .ACTIVE_LOW (ACTIVE_LOW),
         .HOLD_NUM   (HOLD_NUM),
         .REPEAT_NUM (REPEAT_NUM),
         .CNT_W      (CNT_W)
      ) uChan (
         .iClk     (iClk),
         .iRst_n   (iRst_n),
         .iBtn     (iBtn[i]),
         .oPress   (oPress[i]),
         .oRelease (oRelease[i]),
         .oRepeat  (oRepeat[i]),
         .oLevel   (oLevel[i]),
         .oState   (oState[2*i +: 2])
      );
   end

endmodule

// File: tb/tb_btn_debounce_array.sv
// Self-checking bench for btn_debounce_array: directed scenarios plus a
// randomized run against a run-length reference model.
module tb_btn_debounce_array;

   localparam int NB = 4;
   localparam int CN = 4;
   localparam int HN = 10;
   localparam int RN = 5;

   logic          iClk;
   logic          iRst_n;
   logic [NB-1:0] iBtn;
   logic [NB-1:0] oPress, oRelease, oLevel, oRepeat;
   logic [2*NB-1:0] oState;

   int nCompared   = 0;
   int nMismatched = 0;

   btn_debounce_array #(
      .NUM_BTN    (NB),
      .COUNT_NUM  (CN),
      .ACTIVE_LOW (1),
      .HOLD_NUM   (HN),
      .REPEAT_NUM (RN),
      .CNT_W      (8)
   ) dut (
      .iClk     (iClk),
      .iRst_n   (iRst_n),
      .iBtn     (iBtn),
      .oPress   (oPress),
      .oRelease (oRelease),
      .oLevel   (oLevel),
      .oRepeat  (oRepeat),
      .oState   (oState)
   );

   initial iClk = 1'b0;
   always #5 iClk = ~iClk;

   // Reference model: the debounced level flips once the synchronised input has
   // disagreed with it for CN+1 consecutive samples; repeats follow hold age.
   logic [NB-1:0] mS1, mS2, mLevel, mPress, mRel, mRep;
   int            mRun  [NB];
   int            mHeld [NB];

   function automatic bit repeatAge(input int k);
      return (k == HN) || (k > HN && ((k - HN) % RN) == 0);
   endfunction

   always @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         mS1 <= '0; mS2 <= '0; mLevel <= '0;
         mPress <= '0; mRel <= '0; mRep <= '0;
         for (int i = 0; i < NB; i++) begin
            mRun[i]  <= 0;
            mHeld[i] <= 0;
         end
      end else begin
         mS1 <= ~iBtn;
         mS2 <= mS1;
         for (int i = 0; i < NB; i++) begin
            mPress[i] <= 1'b0;
            mRel[i]   <= 1'b0;
            mRep[i]   <= 1'b0;
            if (mS2[i] == mLevel[i]) begin
               mRun[i] <= 0;
            end else if (mRun[i] == CN) begin
               mLevel[i] <= ~mLevel[i];
               mRun[i]   <= 0;
               mPress[i] <= ~mLevel[i];
               mRel[i]   <= mLevel[i];
               mHeld[i]  <= 0;
            end else begin
               mRun[i] <= mRun[i] + 1;
            end
            if (mLevel[i] && !(mS2[i] != mLevel[i] && mRun[i] == CN)) begin
               mHeld[i] <= mHeld[i] + 1;
`ifdef BTN_AUTOREPEAT_EN
               mRep[i] <= repeatAge(mHeld[i] + 1);
`endif
            end
         end
      end
   end

   task automatic tick();
      @(posedge iClk);
      @(negedge iClk);
   endtask

   task automatic goIdle();
      iBtn = '1;
      repeat (12) tick();
   endtask

   task automatic test_reset();
      iRst_n = 1'b0;
      iBtn   = 4'b0111;
      repeat (3) tick();
      nCompared++;
      if ({oPress, oRelease, oRepeat, oLevel, oState} !== '0) begin
         nMismatched++;
         $display("FAIL reset_outputs: got %0h expected 0", {oPress, oRelease, oRepeat, oLevel, oState});
      end
      iRst_n = 1'b1;
      for (int e = 1; e <= 8; e++) begin
         tick();
         if (e == 1) begin
            nCompared++;
            if ({oPress, oRelease, oRepeat, oState} !== '0) begin
               nMismatched++;
               $display("FAIL first_cycle_quiet: got %0h expected 0", {oPress, oRelease, oRepeat, oState});
            end
         end
         nCompared++;
         if (oPress !== ((e == 7) ? 4'b1000 : 4'b0000)) begin
            nMismatched++;
            $display("FAIL held_through_reset edge %0d: got %b expected %b", e, oPress, (e == 7) ? 4'b1000 : 4'b0000);
         end
      end
      goIdle();
   endtask

   task automatic test_clean_press();
      goIdle();
      iBtn[0] = 1'b0;
      for (int e = 1; e <= 9; e++) begin
         tick();
         nCompared++;
         if (oPress[0] !== (e == 7)) begin
            nMismatched++;
            $display("FAIL clean_press edge %0d: got %b expected %b", e, oPress[0], (e == 7));
         end
      end
      nCompared++;
      if (oLevel[0] !== 1'b1 || oState[1:0] !== 2'd2) begin
         nMismatched++;
         $display("FAIL clean_press_level: got level %b state %0d expected level 1 state 2", oLevel[0], oState[1:0]);
      end
   endtask

   task automatic test_bounce();
      int bad = 0;
      goIdle();
      for (int r = 0; r < 5; r++) begin
         iBtn[1] = 1'b0;
         repeat (3) begin
            tick();
            if (oPress[1] !== 1'b0 || oLevel[1] !== 1'b0) bad++;
         end
         iBtn[1] = 1'b1;
         repeat (3) begin
            tick();
            if (oPress[1] !== 1'b0 || oLevel[1] !== 1'b0) bad++;
         end
      end
      nCompared++;
      if (bad !== 0) begin
         nMismatched++;
         $display("FAIL bounce_reject: got %0d bad cycles expected 0", bad);
      end
   endtask

   task automatic test_release_bounce();
      int rel = 0;
      // channel 0 is still held from the clean-press scenario
      iBtn[0] = 1'b1;
      repeat (2) begin tick(); rel += oRelease[0]; end
      iBtn[0] = 1'b0;
      repeat (10) begin tick(); rel += oRelease[0]; end
      nCompared++;
      if (rel !== 0 || oState[1:0] !== 2'd2) begin
         nMismatched++;
         $display("FAIL release_bounce: got %0d pulses state %0d expected 0 pulses state 2", rel, oState[1:0]);
      end
      rel = 0;
      iBtn[0] = 1'b1;
      repeat (6) begin tick(); rel += oRelease[0]; end
      iBtn[0] = 1'b0;
      repeat (6) begin tick(); rel += oRelease[0]; end
      nCompared++;
      if (rel !== 1) begin
         nMismatched++;
         $display("FAIL release_once: got %0d pulses expected 1", rel);
      end
      goIdle();
   endtask

   task automatic test_simultaneous();
      goIdle();
      iBtn = 4'b0000;
      for (int e = 1; e <= 9; e++) begin
         tick();
         nCompared++;
         if (oPress !== ((e == 7) ? 4'b1111 : 4'b0000)) begin
            nMismatched++;
            $display("FAIL simultaneous edge %0d: got %b expected %b", e, oPress, (e == 7) ? 4'b1111 : 4'b0000);
         end
      end
      goIdle();
   endtask

   task automatic test_reset_mid_press();
      goIdle();
      iBtn[0] = 1'b0;
      repeat (5) tick();
      nCompared++;
      if (oState[1:0] !== 2'd1) begin
         nMismatched++;
         $display("FAIL mid_press_state: got %0d expected 1", oState[1:0]);
      end
      iRst_n = 1'b0;
      #1;
      nCompared++;
      if (oState !== '0 || oLevel !== '0) begin
         nMismatched++;
         $display("FAIL mid_press_reset: got state %0h level %b expected 0", oState, oLevel);
      end
      @(negedge iClk);
      iRst_n = 1'b1;
      for (int e = 1; e <= 9; e++) begin
         tick();
         nCompared++;
         if (oPress[0] !== (e == 7)) begin
            nMismatched++;
            $display("FAIL press_after_reset edge %0d: got %b expected %b", e, oPress[0], (e == 7));
         end
      end
      goIdle();
   endtask

   task automatic test_autorepeat();
      goIdle();
      iBtn[2] = 1'b0;
      for (int e = 1; e <= 40; e++) begin
         logic expRep;
`ifdef BTN_AUTOREPEAT_EN
         expRep = (e >= 7 + HN) && ((e - 7 - HN) % RN == 0);
`else
         expRep = 1'b0;
`endif
         tick();
         nCompared++;
         if (oRepeat[2] !== expRep || oPress[2] !== (e == 7)) begin
            nMismatched++;
            $display("FAIL autorepeat edge %0d: got rep %b press %b expected rep %b press %b",
                     e, oRepeat[2], oPress[2], expRep, (e == 7));
         end
      end
      goIdle();
   endtask

   task automatic test_random();
      logic [NB-1:0] tgt;
      int            remain [NB];
      logic [2*NB-1:0] expSt;
      int            bad = 0;
      tgt = '1;
      for (int i = 0; i < NB; i++) remain[i] = 0;
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < NB; i++) begin
            if (remain[i] == 0) begin
               tgt[i]    = ~tgt[i];
               remain[i] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : $urandom_range(5, 30);
            end
            remain[i]--;
         end
         iBtn   = tgt;
         iRst_n = ($urandom_range(0, 499) != 0);
         tick();
         for (int i = 0; i < NB; i++) begin
            if (!mLevel[i]) expSt[2*i +: 2] = (mRun[i] == 0) ? 2'd0 : 2'd1;
            else            expSt[2*i +: 2] = (mRun[i] == 0) ? 2'd2 : 2'd3;
         end
         nCompared++;
         if (oPress !== mPress || oRelease !== mRel || oLevel !== mLevel ||
             oRepeat !== mRep || oState !== expSt ||
             ((oPress & oRelease) | (oPress & oRepeat) | (oRelease & oRepeat)) !== '0) begin
            nMismatched++;
            bad++;
            if (bad <= 10)
               $display("FAIL random cycle %0d: got p%b r%b l%b rep%b s%h expected p%b r%b l%b rep%b s%h",
                        c, oPress, oRelease, oLevel, oRepeat, oState, mPress, mRel, mLevel, mRep, expSt);
         end
      end
      iRst_n = 1'b1;
      goIdle();
   endtask

   initial begin
      iRst_n = 1'b0;
      iBtn   = '1;
      test_reset();
      test_clean_press();
      test_release_bounce();
      test_bounce();
      test_simultaneous();
      test_reset_mid_press();
      test_autorepeat();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
